mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory port,
// pipeline stall outputs and the watchdog error flag.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_data;
  logic          if_ready;
  logic          if_stall;

  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          dm_stall;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          err;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_data, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_data, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) sharing one
// memory port, with alternating priority under contention and an ack watchdog.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  localparam int            CW        = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          last_dm;
  logic          if_pend, dm_pend;
  logic          grant_if, grant_dm, finish, timeout;

  // A requester whose ready is high this cycle is still showing the request
  // that just completed, so it does not count as pending.
  assign if_pend = bus.if_req & ~bus.if_ready;
  assign dm_pend = (bus.dm_read | bus.dm_write) & ~bus.dm_ready;

  assign bus.if_stall = bus.if_req & ~bus.if_ready;
  assign bus.dm_stall = (bus.dm_read | bus.dm_write) & ~bus.dm_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    finish   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_pend && !(if_pend && last_dm)) begin
          grant_dm = 1'b1;
          state_nx = DM_BUSY;
        end else if (if_pend) begin
          grant_if = 1'b1;
          state_nx = IF_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        // ack wins over a timeout landing in the same cycle
        if (bus.mem_ack) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.if_data   <= {DW{1'b0}};
      bus.dm_rdata  <= {DW{1'b0}};
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
      bus.err       <= 1'b0;
      wait_cnt      <= '0;
      last_dm       <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;

      if (grant_dm) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.dm_write;
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_wdata <= bus.dm_wdata;
        wait_cnt      <= '0;
      end else if (grant_if) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= {DW{1'b0}};
        wait_cnt      <= '0;
      end

      // An aborted transaction still hands back a ready, carrying zero data
      if (finish || timeout) begin
        bus.mem_req <= 1'b0;
        last_dm     <= (state == DM_BUSY);
        if (state == IF_BUSY) begin
          bus.if_ready <= 1'b1;
          bus.if_data  <= finish ? bus.mem_rdata : {DW{1'b0}};
        end else begin
          bus.dm_ready <= 1'b1;
          bus.dm_rdata <= finish ? bus.mem_rdata : {DW{1'b0}};
        end
        if (timeout) bus.err <= 1'b1;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, hand-written
// multi-cycle sequences and a randomized run against a cycle-level reference.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) mif ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mif.if_req    = 1'b0;
    mif.if_addr   = '0;
    mif.dm_read   = 1'b0;
    mif.dm_write  = 1'b0;
    mif.dm_addr   = '0;
    mif.dm_wdata  = '0;
    mif.mem_rdata = '0;
    mif.mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- directed transaction table ----------------
  // kind: 0 fetch, 1 read, 2 write, 3 read+write; ack_at: BUSY cycle carrying ack (0 = never)
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    int          exp_lat;
    int          exp_req;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int   reqc = 0;
    int   lat  = 0;
    bit   got  = 0;
    bit   seen = 0;
    do_reset();
    check($sformatf("v%0d_reset_err", idx), mif.err, 0);
    check($sformatf("v%0d_reset_data", idx), {mif.if_data, mif.dm_rdata}, 0);
    mif.if_addr   = v.addr;
    mif.dm_addr   = v.addr;
    mif.dm_wdata  = v.wdata;
    mif.mem_rdata = v.rdata;
    mif.if_req    = (v.kind == 0);
    mif.dm_read   = (v.kind == 1 || v.kind == 3);
    mif.dm_write  = (v.kind >= 2);
    while (!got && lat < 40) begin
      if (mif.mem_req) begin
        reqc++;
        if (!seen) begin
          seen = 1;
          check($sformatf("v%0d_mem_addr", idx), mif.mem_addr, v.addr);
          check($sformatf("v%0d_mem_we", idx), mif.mem_we, v.exp_we);
          if (v.exp_we) check($sformatf("v%0d_mem_wdata", idx), mif.mem_wdata, v.wdata);
        end
      end
      mif.mem_ack = mif.mem_req && (reqc == v.ack_at);
      step();
      lat++;
      got = mif.if_ready | mif.dm_ready;
    end
    mif.mem_ack = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_req_cycles", idx), reqc, v.exp_req);
    check($sformatf("v%0d_mem_req_drop", idx), mif.mem_req, 0);
    check($sformatf("v%0d_err", idx), mif.err, v.exp_err);
    if (v.kind == 0) begin
      check($sformatf("v%0d_ready_pair", idx), {mif.if_ready, mif.dm_ready}, 2'b10);
      check($sformatf("v%0d_if_data", idx), mif.if_data, v.exp_data);
      check($sformatf("v%0d_if_stall", idx), mif.if_stall, 0);
    end else begin
      check($sformatf("v%0d_ready_pair", idx), {mif.if_ready, mif.dm_ready}, 2'b01);
      check($sformatf("v%0d_dm_rdata", idx), mif.dm_rdata, v.exp_data);
      check($sformatf("v%0d_dm_stall", idx), mif.dm_stall, 0);
    end
    mif.if_req = 1'b0; mif.dm_read = 1'b0; mif.dm_write = 1'b0;
    step();
    check($sformatf("v%0d_ready_pulse", idx), {mif.if_ready, mif.dm_ready}, 0);
    step();
    step();
    check($sformatf("v%0d_err_sticky", idx), mif.err, v.exp_err);
    if (v.kind == 0) check($sformatf("v%0d_if_data_hold", idx), mif.if_data, v.exp_data);
    else             check($sformatf("v%0d_dm_rdata_hold", idx), mif.dm_rdata, v.exp_data);
  endtask

  // ---------------- reference model ----------------
  int          m_owner;      // 0 nobody, 1 fetch, 2 data
  int          m_busy;
  bit          m_last_data;
  logic        e_mem_req, e_mem_we, e_if_ready, e_dm_ready, e_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_data, e_dm_rdata;

  task automatic model_step();
    bit          fw, dw;
    logic [31:0] d;
    if (reset) begin
      m_owner = 0; m_busy = 0; m_last_data = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_if_data = 0; e_dm_rdata = 0; e_if_ready = 0; e_dm_ready = 0; e_err = 0;
      return;
    end
    fw = mif.if_req && !e_if_ready;
    dw = (mif.dm_read || mif.dm_write) && !e_dm_ready;
    e_if_ready = 0;
    e_dm_ready = 0;
    if (m_owner == 0) begin
      if (dw && (!fw || !m_last_data)) begin
        m_owner = 2; m_busy = 0; e_mem_req = 1;
        e_mem_addr = mif.dm_addr; e_mem_we = mif.dm_write; e_mem_wdata = mif.dm_wdata;
      end else if (fw) begin
        m_owner = 1; m_busy = 0; e_mem_req = 1;
        e_mem_addr = mif.if_addr; e_mem_we = 0;
      end
    end else begin
      m_busy++;
      if (mif.mem_ack || m_busy == MAX_WAIT) begin
        d = mif.mem_ack ? mif.mem_rdata : 32'h0;
        if (m_owner == 1) begin e_if_ready = 1; e_if_data = d; end
        else              begin e_dm_ready = 1; e_dm_rdata = d; end
        if (!mif.mem_ack) e_err = 1;
        m_last_data = (m_owner == 2);
        m_owner = 0;
        e_mem_req = 0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grants[$];
    bit prev_req;
    int rises[$];
    int ack_pct;

    clear_inputs();
    reset = 1'b1;
    step();
    step();
    check("reset_outputs",
          {mif.mem_req, mif.mem_we, mif.if_ready, mif.dm_ready, mif.err, mif.if_stall, mif.dm_stall}, 0);
    check("reset_buses", {mif.mem_addr, mif.mem_wdata}, 0);
    reset = 1'b0;

    //            kind addr          wdata         rdata         ack lat req we data          err
    vecs[0] = '{0, 32'h0000_0040, 32'h0,        32'h2002_000A, 3,  4,  3,  0, 32'h2002_000A, 0};
    vecs[1] = '{2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1,  2,  1,  1, 32'h0,        0};
    vecs[2] = '{1, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 1,  2,  1,  0, 32'hCAFE_F00D, 0};
    vecs[3] = '{3, 32'h0000_0300, 32'h1234_5678, 32'h0,        2,  3,  2,  1, 32'h0,        0};
    vecs[4] = '{0, 32'h0000_0444, 32'h0,        32'h55AA_55AA, 14, 15, 14, 0, 32'h55AA_55AA, 0};
    vecs[5] = '{1, 32'h0000_0500, 32'h0,        32'hA5A5_A5A5, 15, 16, 15, 0, 32'hA5A5_A5A5, 0};
    vecs[6] = '{1, 32'h0000_0600, 32'h0,        32'h9999_9999, 0,  16, 15, 0, 32'h0,        1};
    vecs[7] = '{0, 32'h0000_0700, 32'h0,        32'h7777_7777, 0,  16, 15, 0, 32'h0,        1};
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Both requesters held: grants must alternate data, fetch, data, fetch
    do_reset();
    mif.if_addr = 32'h80; mif.dm_addr = 32'h180; mif.mem_rdata = 32'h1;
    mif.if_req = 1'b1; mif.dm_read = 1'b1;
    prev_req = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      if (mif.mem_req && !prev_req) grants.push_back(mif.mem_addr == 32'h180 ? 1 : 0);
      prev_req = mif.mem_req;
      mif.mem_ack = mif.mem_req;
      step();
    end
    check("alt_grant_count", grants.size(), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      check($sformatf("alt_grant%0d", g), grants[g], (g % 2 == 0) ? 1 : 0);

    // Single requester held: no regrant in its ready cycle
    do_reset();
    mif.dm_read = 1'b1; mif.dm_addr = 32'h20;
    prev_req = 0;
    for (int c = 0; c < 20 && rises.size() < 2; c++) begin
      if (mif.mem_req && !prev_req) rises.push_back(c);
      prev_req = mif.mem_req;
      mif.mem_ack = mif.mem_req;
      step();
    end
    check("stale_rise_count", rises.size(), 2);
    if (rises.size() == 2) check("stale_gap", rises[1] - rises[0], 3);

    // Reset on the second BUSY cycle aborts silently; later ack is ignored
    do_reset();
    mif.dm_write = 1'b1; mif.dm_addr = 32'h55; mif.dm_wdata = 32'hFEED_0001;
    step();
    check("rst_mid_busy", mif.mem_req, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mif.dm_write = 1'b0;
    check("rst_mid_ctrl", {mif.mem_req, mif.mem_we, mif.if_ready, mif.dm_ready, mif.err}, 0);
    check("rst_mid_bus", {mif.mem_addr, mif.mem_wdata}, 0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("idle_ack_ignored%0d", c), {mif.mem_req, mif.if_ready, mif.dm_ready}, 0);
    end
    mif.mem_ack = 1'b0;

    // Requester withdraws mid-transaction: still completes with a ready
    do_reset();
    mif.if_req = 1'b1; mif.if_addr = 32'h44;
    step();
    mif.if_req = 1'b0;
    step();
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_0077;
    step();
    mif.mem_ack = 1'b0;
    check("withdraw_ready", mif.if_ready, 1);
    check("withdraw_data", mif.if_data, 32'h77);

    // Randomized run against the reference model
    do_reset();
    reset = 1'b1;
    model_step();
    step();
    reset = 1'b0;
    ack_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) ack_pct = $urandom_range(0, 3) * 25;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0) begin
        mif.if_req  = $urandom_range(0, 1);
        mif.if_addr = $urandom;
      end
      if ($urandom_range(0, 4) == 0) begin
        mif.dm_read  = $urandom_range(0, 1);
        mif.dm_write = $urandom_range(0, 1);
        mif.dm_addr  = $urandom;
        mif.dm_wdata = $urandom;
      end
      mif.mem_ack   = ($urandom_range(0, 99) < ack_pct);
      mif.mem_rdata = $urandom;
      #1;
      check("rnd_if_stall", mif.if_stall, mif.if_req & ~e_if_ready);
      check("rnd_dm_stall", mif.dm_stall, (mif.dm_read | mif.dm_write) & ~e_dm_ready);
      model_step();
      step();
      check("rnd_mem_req", mif.mem_req, e_mem_req);
      check("rnd_mem_we", mif.mem_we, e_mem_we);
      check("rnd_mem_addr", mif.mem_addr, e_mem_addr);
      if (e_mem_we) check("rnd_mem_wdata", mif.mem_wdata, e_mem_wdata);
      check("rnd_ready", {mif.if_ready, mif.dm_ready}, {e_if_ready, e_dm_ready});
      check("rnd_if_data", mif.if_data, e_if_data);
      check("rnd_dm_rdata", mif.dm_rdata, e_dm_rdata);
      check("rnd_err", mif.err, e_err);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
